// File: rtl/aes_pkg.sv
// aes_pkg: shared AES loader types, constants and slot-offset helper
//   AES_NBYTES  bytes per 128-bit AES state
//   aes_state_t 128-bit column-major state word
//   aes_byte_t  8-bit state byte
//   ld_state_t  loader FSM encoding (FILL / FULL / DRAIN)
//   byte_slice  bit offset of byte slot k inside the state word
package aes_pkg;

    localparam int AES_NBYTES = 16;

    typedef logic [127:0] aes_state_t;
    typedef logic [7:0]   aes_byte_t;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        FULL  = 2'd1,
        DRAIN = 2'd2
    } ld_state_t;

    // first_msb=1 puts slot 0 at [127:120] (s00); otherwise slot 0 sits at [7:0]
    function automatic logic [6:0] byte_slice(input logic [3:0] k, input logic first_msb);
        return first_msb ? 7'd120 - {k, 3'b000} : {k, 3'b000};
    endfunction

endpackage

// File: rtl/aes_state_loader.sv
// aes_state_loader: byte-serial to 128-bit AES state assembler with framing checks
//   i_clk          clock, rising edge
//   i_rst          asynchronous active-high reset
//   i_e_d_in       mode for the frame (1 encrypt, 0 decrypt), sampled with byte 0
//   i_byte_valid   input byte present
//   i_byte_data    input byte
//   i_byte_last    final byte of a frame
//   o_byte_ready   loader accepts i_byte_data this cycle
//   o_dout         assembled column-major state
//   o_e_d          mode tag travelling with o_dout
//   o_dout_valid   o_dout/o_e_d hold a complete frame
//   i_dout_ready   downstream takes the frame
//   o_frame_err    one-cycle pulse on a framing violation
//   o_busy         a frame is partially loaded or a bad frame is being drained
module aes_state_loader
    import aes_pkg::*;
#(
    parameter int NBYTES    = AES_NBYTES,
    parameter bit FIRST_MSB = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_e_d_in,
    input  logic             i_byte_valid,
    input  logic [7:0]       i_byte_data,
    input  logic             i_byte_last,
    output logic             o_byte_ready,
    output logic [127:0]     o_dout,
    output logic             o_e_d,
    output logic             o_dout_valid,
    input  logic             i_dout_ready,
    output logic             o_frame_err,
    output logic             o_busy
);

    localparam logic [3:0] LAST_SLOT = 4'(NBYTES - 1);

    ld_state_t  r_state;
    ld_state_t  w_next_state;
    logic [3:0] r_cnt;
    logic [3:0] w_next_cnt;
    logic [3:0] w_slot;
    aes_state_t r_dout;
    logic       r_e_d;
    logic       r_frame_err;
    logic       w_byte_ready;
    logic       w_byte_acc;
    logic       w_out_acc;
    logic       w_take;
    logic       w_last_slot;
    logic       w_err;

    always_comb begin
        // held low during reset so nothing looks accepted while the loader is cleared
        w_byte_ready = ~i_rst & ((r_state == FULL) ? i_dout_ready : 1'b1);
        w_byte_acc   = i_byte_valid & w_byte_ready;
        w_out_acc    = (r_state == FULL) & i_dout_ready;
        // in FULL a byte can only be accepted together with the frame release; it starts the next frame
        w_take       = w_byte_acc & (r_state != DRAIN);
        w_slot       = (r_state == FULL) ? 4'd0 : r_cnt;
        w_last_slot  = (w_slot == LAST_SLOT);
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_err        = 1'b0;
        if (r_state == DRAIN && w_byte_acc && i_byte_last)
            w_next_state = FILL;
        if (w_out_acc && !w_byte_acc)
            w_next_state = FILL;
        if (w_take) begin
            w_next_cnt   = (i_byte_last || w_last_slot) ? 4'd0 : w_slot + 4'd1;
            // early last or missing last on the final slot are both framing errors
            w_err        = i_byte_last ^ w_last_slot;
            w_next_state = (i_byte_last && w_last_slot) ? FULL : (w_last_slot ? DRAIN : FILL);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= FILL;
            r_cnt       <= 4'd0;
            r_dout      <= '0;
            r_e_d       <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_cnt       <= w_next_cnt;
            r_frame_err <= w_err;
            if (w_take) begin
                r_dout[byte_slice(w_slot, FIRST_MSB) +: 8] <= i_byte_data;
                if (w_slot == 4'd0)
                    r_e_d <= i_e_d_in;
            end
        end
    end

    assign o_byte_ready = w_byte_ready;
    assign o_dout       = r_dout;
    assign o_e_d        = r_e_d;
    assign o_dout_valid = (r_state == FULL);
    assign o_frame_err  = r_frame_err;
    assign o_busy       = (r_cnt != 4'd0) | (r_state == DRAIN);

endmodule
